// File: rtl/priority_code_queue.sv
// priority_code_queue
//   Queues the winning index of a clocked 16-to-4 priority encoder for a
//   downstream dispatcher. An index is enqueued only when it differs from the
//   last accepted sample, so a held request yields a single entry.
//
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous, active-high reset
//     G3..G0     encoder index (G3 = MSB)
//     any_req    qualifies G; high when any encoder input is set
//     out_ready  dispatcher takes the head entry this cycle
//     clear_ovf  synchronous clear of the sticky overflow flag
//     Q          head-of-queue index (holds its last head value when empty)
//     out_valid  queue non-empty
//     count      current occupancy, 0..DEPTH
//     overflow   sticky: a new index was dropped because the queue was full
module priority_code_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             G0,
  input  logic             G1,
  input  logic             G2,
  input  logic             G3,
  input  logic             any_req,
  input  logic             out_ready,
  input  logic             clear_ovf,
  output logic [3:0]       Q,
  output logic             out_valid,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]       code;

  logic [3:0]       mem_q [DEPTH];
  logic [3:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       q_q, q_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       last_code_q, last_code_d;
  logic             last_valid_q, last_valid_d;

  logic             full;
  logic             empty;
  logic             new_code;
  logic             push;
  logic             pop;

  assign code     = {G3, G2, G1, G0};
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign new_code = any_req && (!last_valid_q || (code != last_code_q));
  assign pop      = !empty && out_ready;
  // A same-cycle pop frees the slot, so a full queue still accepts the write.
  assign push     = new_code && (!full || pop);

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    q_d          = q_q;
    ovf_d        = ovf_q;
    last_code_d  = last_code_q;
    last_valid_d = last_valid_q;

    if (push) begin
      mem_d[wr_ptr_q] = code;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Q is registered: load the next head (which may be the entry written
    // this very cycle, hence read from mem_d); hold it once the queue drains.
    if (count_d != '0) begin
      q_d = mem_d[rd_ptr_d];
    end

    // A drop in the same cycle as clear_ovf keeps the flag set.
    if (new_code && full && !pop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end

    if (any_req) begin
      last_code_d  = code;
      last_valid_d = 1'b1;
    end else begin
      last_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      q_q          <= '0;
      ovf_q        <= 1'b0;
      last_code_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      q_q          <= q_d;
      ovf_q        <= ovf_d;
      last_code_q  <= last_code_d;
      last_valid_q <= last_valid_d;
    end
  end

  assign Q         = q_q;
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_priority_code_queue.sv
// Bench for priority_code_queue: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model.
module tb_priority_code_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       G0, G1, G2, G3;
  logic       any_req, out_ready, clear_ovf;
  logic [3:0] Q;
  logic       out_valid;
  logic [2:0] count;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [3:0] m_q[$];
  logic [3:0] m_head;
  logic       m_ovf;
  logic [3:0] m_last;
  logic       m_last_v;

  priority_code_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .G0(G0), .G1(G1), .G2(G2), .G3(G3),
    .any_req(any_req), .out_ready(out_ready), .clear_ovf(clear_ovf),
    .Q(Q), .out_valid(out_valid), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_head   = '0;
    m_ovf    = 1'b0;
    m_last   = '0;
    m_last_v = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".Q"},         32'(Q),         32'(m_head));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() != 0));
    check({tag, ".count"},     32'(count),     32'(m_q.size()));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
  endtask

  // Apply one cycle of inputs, advance the model by the rules, compare after the edge.
  task automatic cycle(input logic ar, input logic [3:0] c, input logic rdy,
                       input logic clr, input string tag);
    logic valid, pp, full, newc, ps;
    any_req = ar; {G3, G2, G1, G0} = c; out_ready = rdy; clear_ovf = clr;
    valid = (m_q.size() != 0);
    pp    = valid && rdy;
    full  = (m_q.size() == DEPTH);
    newc  = ar && (!m_last_v || c != m_last);
    ps    = newc && (!full || pp);
    if (pp) void'(m_q.pop_front());
    if (ps) m_q.push_back(c);
    if (newc && full && !pp) m_ovf = 1'b1;
    else if (clr)            m_ovf = 1'b0;
    if (ar) begin m_last = c; m_last_v = 1'b1; end
    else    m_last_v = 1'b0;
    if (m_q.size() != 0) m_head = m_q[0];
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    any_req = 0; out_ready = 0; clear_ovf = 0;
    {G3, G2, G1, G0} = 4'd0;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Held request produces one entry
    for (int i = 0; i < 5; i++) cycle(1, 4'd4, 0, 0, "hold4");
    check("hold4.count_const", 32'(count), 32'd1);
    check("hold4.Q_const",     32'(Q),     32'd4);

    // Drain, then ordered push/pop
    cycle(0, 4'd0, 1, 0, "drain");
    cycle(1, 4'd4, 0, 0, "seq");
    cycle(1, 4'd7, 0, 0, "seq");
    cycle(1, 4'd4, 0, 0, "seq");
    cycle(1, 4'd2, 0, 0, "seq");
    check("seq.count_full", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) cycle(0, 4'd0, 1, 0, "seqpop");
    check("seqpop.empty", 32'(out_valid), 32'd0);
    check("seqpop.Q_hold", 32'(Q), 32'd2);

    // Overflow drop, accept-on-pop, clear, clear-vs-drop priority
    cycle(1, 4'd1, 0, 0, "fill"); cycle(1, 4'd2, 0, 0, "fill");
    cycle(1, 4'd3, 0, 0, "fill"); cycle(1, 4'd4, 0, 0, "fill");
    cycle(1, 4'd9, 0, 0, "drop9");
    check("drop9.ovf_const", 32'(overflow), 32'd1);
    cycle(0, 4'd0, 0, 0, "idle");
    cycle(1, 4'd9, 1, 0, "accept9");
    check("accept9.count_const", 32'(count), 32'd4);
    cycle(0, 4'd0, 0, 1, "clr");
    check("clr.ovf_const", 32'(overflow), 32'd0);
    cycle(1, 4'd6, 0, 1, "clr_vs_drop");
    check("clr_vs_drop.ovf_const", 32'(overflow), 32'd1);
    cycle(0, 4'd0, 0, 1, "clr2");
    for (int i = 0; i < 4; i++) cycle(0, 4'd0, 1, 0, "drain2");

    // Same index after an idle cycle enqueues twice; index 0 with any_req works
    cycle(1, 4'd5, 0, 0, "re5"); cycle(0, 4'd5, 0, 0, "re5"); cycle(1, 4'd5, 0, 0, "re5");
    check("re5.count_const", 32'(count), 32'd2);
    cycle(1, 4'd0, 0, 0, "zero");
    for (int i = 0; i < 3; i++) cycle(0, 4'd0, 1, 0, "drain3");

    // Streaming with out_ready held high
    cycle(1, 4'd1, 1, 0, "stream"); cycle(1, 4'd2, 1, 0, "stream"); cycle(1, 4'd3, 1, 0, "stream");
    check("stream.Q3", 32'(Q), 32'd3);
    cycle(0, 4'd0, 1, 0, "stream_end");

    // Asynchronous reset with entries queued
    cycle(1, 4'd8, 0, 0, "pre"); cycle(1, 4'd10, 0, 0, "pre"); cycle(1, 4'd11, 0, 0, "pre");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2 reset = 1'b0;
    cycle(1, 4'd11, 0, 0, "post_rst");
    check("post_rst.count_const", 32'(count), 32'd1);
    cycle(0, 4'd0, 1, 0, "post_drain");

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3) * 5),
            ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_code_queue.md
Name: priority_code_queue

Overview:
- Downstream consumer of the clocked 16-to-4 priority encoder.
- Samples the encoder's 4-bit winning index G3..G0 each clock, qualified by an upstream any-request flag.
- Enqueues an index only when it differs from the last one accepted, so a held request produces one entry.
- Presents queued indices to a dispatcher over a valid/ready handshake, with occupancy count and sticky overflow flag.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 3, width of count output; must hold 0..DEPTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- G0  input  1  encoder index bit 0 (LSB)
- G1  input  1  encoder index bit 1
- G2  input  1  encoder index bit 2
- G3  input  1  encoder index bit 3 (MSB)
- any_req  input  1  high when at least one D input to the encoder is set; qualifies G
- out_ready  input  1  dispatcher accepts head entry this cycle
- clear_ovf  input  1  synchronous clear of overflow flag
- Q  output  4  head-of-queue index
- out_valid  output  1  queue non-empty; Q is meaningful
- count  output  CNT_W  current occupancy
- overflow  output  1  sticky: a new index was dropped because the queue was full

Behaviour:
- Clocking: one clock, all state on rising clk edge. reset is asynchronous and active-high and overrides everything.
- Reset values:
  - Q=0, out_valid=0, count=0, overflow=0.
  - Read and write pointers = 0.
  - last_code=0, last_valid=0.
- Index: code = {G3,G2,G1,G0}.
- Change detect: new_code = any_req && (!last_valid || code != last_code).
- Last-code tracking:
  - On any edge with any_req=1: last_code <= code and last_valid <= 1, whether or not the push succeeds.
  - On any edge with any_req=0: last_valid <= 0, so the same index re-asserted after an idle cycle is enqueued again.
- Push: push = new_code && (!full || pop). A pop in the same cycle frees the slot, so a full queue with a simultaneous pop accepts the write.
- Pop: pop = out_valid && out_ready. The head advances on that edge.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - On an empty queue a push with out_ready=1 cannot pop, because out_valid is still 0.
- Pointers and count:
  - Pointers are log2(DEPTH) bits and wrap naturally at DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- Overflow:
  - Set when new_code && full && !pop; the sample is dropped.
  - Held until reset or clear_ovf=1.
  - If clear_ovf and a new drop occur in the same cycle, set wins.
- Outputs: Q is driven from storage[rd_ptr] and out_valid = !empty, both from registered state.
  - Latency: an index sampled at edge N appears on Q with out_valid=1 after edge N when the queue was empty.
  - Q holds its last head value when empty; it is not forced to 0 except by reset.
- Reset mid-operation: queue contents are discarded immediately (asynchronously). No pending entry is emitted after reset deasserts.
- Ambiguity: index 0 with any_req=0 is never enqueued. Index 0 with any_req=1 (D0 is the winner) is enqueued normally.

Test Plan:
- Reset, then any_req=1 with code=4 held for 5 cycles, out_ready=0 -> exactly one entry; count=1, Q=4, out_valid=1, overflow=0.
- Codes 4,7,4,2 on consecutive cycles with any_req=1, out_ready=0 -> count=4, then pops return Q=4,7,4,2 in order; out_valid=0 after the fourth pop.
- Fill to 4 entries, present new code 9 with out_ready=0 -> dropped, overflow=1, count=4. Same again with out_ready=1 on that cycle -> 9 accepted, count stays 4, overflow unchanged.
- Code 5 with any_req=1 for one cycle, any_req=0 for one cycle, then code 5 again -> two entries of 5. Assert clear_ovf after an overflow -> overflow=0 next cycle.
- out_ready=1 permanently, codes 1,2,3 on successive cycles -> each appears on Q one cycle after sampling, count never exceeds 1, no overflow.
- 3 entries queued, assert reset mid-cycle (asynchronously) -> out_valid, count, Q and overflow go to 0 without waiting for clk. After release the first sampled code is enqueued even if it equals the pre-reset last code.
